// File: rtl/em_pipe_reg.sv
// Execute->Memory pipeline register with bubble, exception flush and exception squash handling.
// Optional macro EM_BD_TRACK_EN: when defined, the branch-delay flag is registered; otherwise M_BD is tied low.
`timescale 1ns/1ps

module em_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Instr,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_BD,
  input  logic [31:0] E_ALUOut,
  input  logic [31:0] E_RtData,
  input  logic [4:0]  E_RegAddr,
  input  logic        E_MemWrEn,
  input  logic [1:0]  E_Tnew,
  output logic [31:0] M_PC,
  output logic [31:0] M_Instr,
  output logic [4:0]  M_ExcCode,
  output logic        M_BD,
  output logic [31:0] M_ALUOut,
  output logic [31:0] M_RtData,
  output logic [4:0]  M_RegAddr,
  output logic        M_MemWrEn,
  output logic [1:0]  M_Tnew,
  output logic        M_Valid
);

  // One stage closer to the result: saturate at zero instead of wrapping to 3.
  function automatic logic [1:0] tnewDec(input logic [1:0] tnew);
    logic [1:0] res;
    case (tnew)
      2'd0:    res = 2'd0;
      2'd1:    res = 2'd0;
      2'd2:    res = 2'd1;
      2'd3:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  logic hasExc_s;
  logic [1:0] tnewNext_s;

  assign hasExc_s   = (E_ExcCode != 5'd0);
  assign tnewNext_s = tnewDec(E_Tnew);

  // Main bundle register: priority reset > Req > flush > en > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      M_PC      <= RESET_PC;
      M_Instr   <= 32'd0;
      M_ExcCode <= 5'd0;
      M_ALUOut  <= 32'd0;
      M_RtData  <= 32'd0;
      M_RegAddr <= 5'd0;
      M_MemWrEn <= 1'b0;
      M_Tnew    <= 2'd0;
      M_Valid   <= 1'b0;
    end else if (Req) begin
      M_PC      <= HANDLER_PC;
      M_Instr   <= 32'd0;
      M_ExcCode <= 5'd0;
      M_ALUOut  <= 32'd0;
      M_RtData  <= 32'd0;
      M_RegAddr <= 5'd0;
      M_MemWrEn <= 1'b0;
      M_Tnew    <= 2'd0;
      M_Valid   <= 1'b0;
    end else if (flush) begin
      // Bubble keeps PC so CP0 still sees the right EPC for a stalled slot.
      M_PC      <= E_PC;
      M_Instr   <= 32'd0;
      M_ExcCode <= 5'd0;
      M_ALUOut  <= 32'd0;
      M_RtData  <= 32'd0;
      M_RegAddr <= 5'd0;
      M_MemWrEn <= 1'b0;
      M_Tnew    <= 2'd0;
      M_Valid   <= 1'b0;
    end else if (en) begin
      M_PC      <= E_PC;
      M_Instr   <= E_Instr;
      M_ExcCode <= E_ExcCode;
      M_ALUOut  <= E_ALUOut;
      M_RtData  <= E_RtData;
      M_RegAddr <= hasExc_s ? 5'd0 : E_RegAddr;
      M_MemWrEn <= hasExc_s ? 1'b0 : E_MemWrEn;
      M_Tnew    <= tnewNext_s;
      M_Valid   <= 1'b1;
    end else begin
      M_PC      <= M_PC;
      M_Instr   <= M_Instr;
      M_ExcCode <= M_ExcCode;
      M_ALUOut  <= M_ALUOut;
      M_RtData  <= M_RtData;
      M_RegAddr <= M_RegAddr;
      M_MemWrEn <= M_MemWrEn;
      M_Tnew    <= M_Tnew;
      M_Valid   <= M_Valid;
    end
  end

`ifdef EM_BD_TRACK_EN
  // Branch-delay flag follows PC on flush and capture; cleared on handler entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      M_BD <= 1'b0;
    end else if (Req) begin
      M_BD <= 1'b0;
    end else if (flush) begin
      M_BD <= E_BD;
    end else if (en) begin
      M_BD <= E_BD;
    end else begin
      M_BD <= M_BD;
    end
  end
`else
  logic unusedBd_s;
  assign unusedBd_s = E_BD;
  assign M_BD       = 1'b0;
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// Self-checking bench for em_pipe_reg: directed scenarios plus randomized traffic against a rule-level model.
`timescale 1ns/1ps

module tb_em_pipe_reg;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] HND_PC = 32'h0000_4180;
`ifdef EM_BD_TRACK_EN
  localparam bit BD_ON = 1'b1;
`else
  localparam bit BD_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  regAddr;
    logic        memWr;
    logic [1:0]  tnew;
    logic        valid;
  } bundle_t;

  logic clk = 1'b0;
  logic reset, Req, en, flush;
  logic [31:0] E_PC, E_Instr, E_ALUOut, E_RtData;
  logic [4:0]  E_ExcCode, E_RegAddr;
  logic        E_BD, E_MemWrEn;
  logic [1:0]  E_Tnew;
  logic [31:0] M_PC, M_Instr, M_ALUOut, M_RtData;
  logic [4:0]  M_ExcCode, M_RegAddr;
  logic        M_BD, M_MemWrEn, M_Valid;
  logic [1:0]  M_Tnew;

  bundle_t obs, expd, rstVal;
  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  em_pipe_reg dut (
    .clk(clk), .reset(reset), .Req(Req), .en(en), .flush(flush),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_ExcCode(E_ExcCode), .E_BD(E_BD),
    .E_ALUOut(E_ALUOut), .E_RtData(E_RtData), .E_RegAddr(E_RegAddr),
    .E_MemWrEn(E_MemWrEn), .E_Tnew(E_Tnew),
    .M_PC(M_PC), .M_Instr(M_Instr), .M_ExcCode(M_ExcCode), .M_BD(M_BD),
    .M_ALUOut(M_ALUOut), .M_RtData(M_RtData), .M_RegAddr(M_RegAddr),
    .M_MemWrEn(M_MemWrEn), .M_Tnew(M_Tnew), .M_Valid(M_Valid)
  );

  assign obs = {M_PC, M_Instr, M_ExcCode, M_BD, M_ALUOut, M_RtData,
                M_RegAddr, M_MemWrEn, M_Tnew, M_Valid};

  // Expected register contents after one edge, from the priority rules.
  function automatic bundle_t modelNext(input bundle_t cur);
    bundle_t n;
    int t;
    n = cur;
    if (Req) begin
      n = '0;
      n.pc = HND_PC;
    end else if (flush) begin
      n = '0;
      n.pc = E_PC;
      n.bd = BD_ON ? E_BD : 1'b0;
    end else if (en) begin
      t = int'(E_Tnew) - 1;
      if (t < 0) t = 0;
      n.pc = E_PC; n.instr = E_Instr; n.exc = E_ExcCode;
      n.bd = BD_ON ? E_BD : 1'b0;
      n.alu = E_ALUOut; n.rt = E_RtData;
      n.regAddr = (E_ExcCode == 5'd0) ? E_RegAddr : 5'd0;
      n.memWr   = (E_ExcCode == 5'd0) ? E_MemWrEn : 1'b0;
      n.tnew = t[1:0];
      n.valid = 1'b1;
    end
    return n;
  endfunction

  task automatic randBundle();
    E_PC = $urandom; E_Instr = $urandom; E_ALUOut = $urandom; E_RtData = $urandom;
    E_ExcCode = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    E_RegAddr = 5'($urandom); E_BD = 1'($urandom); E_MemWrEn = 1'($urandom);
    E_Tnew = 2'($urandom);
  endtask

  // Apply controls, advance one edge, land 1ns after it.
  task automatic cycle(input logic r, input logic f, input logic e);
    Req = r; flush = f; en = e;
    expd = modelNext(expd);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstVal = '0; rstVal.pc = RST_PC;
    reset = 1'b1; Req = 1'b0; flush = 1'b0; en = 1'b0;
    randBundle();
    repeat (2) @(posedge clk);
    #1;
    expd = rstVal;
    nChecks++;
    if (obs !== rstVal) begin nFails++; $display("FAIL reset_state got=%h exp=%h", obs, rstVal); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randBundle();
      cycle(1'b0, 1'b0, 1'b0);
      nChecks++;
      if (obs !== rstVal) begin nFails++; $display("FAIL reset_hold%0d got=%h exp=%h", i, obs, rstVal); end
    end
  endtask

  task automatic test_capture();
    logic [1:0] tn [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic [1:0] tx [4] = '{2'd1, 2'd0, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      randBundle();
      E_PC = 32'h0000_3010 + 32'(i * 4); E_RegAddr = 5'd8; E_Tnew = tn[i]; E_ExcCode = 5'd0;
      cycle(1'b0, 1'b0, 1'b1);
      nChecks++;
      if (M_PC !== 32'h0000_3010 + 32'(i * 4) || M_RegAddr !== 5'd8 || M_Tnew !== tx[i] || M_Valid !== 1'b1) begin
        nFails++;
        $display("FAIL capture%0d got pc=%h reg=%0d tnew=%0d v=%b exp tnew=%0d", i, M_PC, M_RegAddr, M_Tnew, M_Valid, tx[i]);
      end
      nChecks++;
      if (obs !== expd) begin nFails++; $display("FAIL capture_full%0d got=%h exp=%h", i, obs, expd); end
    end
    // en low holds whatever was captured
    randBundle();
    cycle(1'b0, 1'b0, 1'b0);
    nChecks++;
    if (obs !== expd || M_Valid !== 1'b1) begin nFails++; $display("FAIL hold got=%h exp=%h", obs, expd); end
  endtask

  task automatic test_squash();
    randBundle();
    E_ExcCode = 5'd4; E_RegAddr = 5'd9; E_MemWrEn = 1'b1; E_ALUOut = 32'h0000_0001;
    cycle(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (M_ExcCode !== 5'd4 || M_ALUOut !== 32'h0000_0001 || M_RegAddr !== 5'd0 || M_MemWrEn !== 1'b0 || M_Valid !== 1'b1) begin
      nFails++;
      $display("FAIL squash got exc=%0d alu=%h reg=%0d mw=%b v=%b exp exc=4 alu=1 reg=0 mw=0 v=1", M_ExcCode, M_ALUOut, M_RegAddr, M_MemWrEn, M_Valid);
    end
    nChecks++;
    if (obs !== expd) begin nFails++; $display("FAIL squash_full got=%h exp=%h", obs, expd); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      randBundle();
      E_PC = 32'h0000_3020; E_BD = 1'b1; E_ExcCode = 5'd0; E_RegAddr = 5'd7;
      cycle(1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
      nChecks++;
      if (M_PC !== 32'h0000_3020 || M_BD !== BD_ON || M_Valid !== 1'b0 || M_RegAddr !== 5'd0 || M_Instr !== 32'd0) begin
        nFails++;
        $display("FAIL flush%0d got pc=%h bd=%b v=%b reg=%0d instr=%h exp pc=3020 bd=%b", i, M_PC, M_BD, M_Valid, M_RegAddr, M_Instr, BD_ON);
      end
      nChecks++;
      if (obs !== expd) begin nFails++; $display("FAIL flush_full%0d got=%h exp=%h", i, obs, expd); end
    end
  endtask

  task automatic test_req();
    randBundle();
    E_ExcCode = 5'd12; E_BD = 1'b1;
    cycle(1'b1, 1'b1, 1'b1);
    nChecks++;
    if (M_PC !== HND_PC || M_Valid !== 1'b0 || M_ExcCode !== 5'd0 || M_BD !== 1'b0) begin
      nFails++;
      $display("FAIL req got pc=%h v=%b exc=%0d bd=%b exp pc=%h v=0 exc=0 bd=0", M_PC, M_Valid, M_ExcCode, M_BD, HND_PC);
    end
    nChecks++;
    if (obs !== expd) begin nFails++; $display("FAIL req_full got=%h exp=%h", obs, expd); end
  endtask

  task automatic test_async_reset();
    randBundle();
    cycle(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (M_Valid !== 1'b1) begin nFails++; $display("FAIL areset_pre valid got=%b exp=1", M_Valid); end
    #2;
    reset = 1'b1;
    #1;
    expd = rstVal;
    nChecks++;
    if (obs !== rstVal) begin nFails++; $display("FAIL areset_async got=%h exp=%h", obs, rstVal); end
    @(posedge clk); #1;
    nChecks++;
    if (obs !== rstVal) begin nFails++; $display("FAIL areset_held got=%h exp=%h", obs, rstVal); end
    reset = 1'b0;
    randBundle();
    cycle(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (obs !== expd || M_Valid !== 1'b1) begin nFails++; $display("FAIL areset_first_capture got=%h exp=%h", obs, expd); end
  endtask

  task automatic test_random();
    logic r, f, e;
    for (int i = 0; i < 400; i++) begin
      randBundle();
      r = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 3) != 0);
      cycle(r, f, e);
      nChecks++;
      if (obs !== expd) begin nFails++; $display("FAIL random%0d req=%b fl=%b en=%b got=%h exp=%h", i, r, f, e, obs, expd); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_squash();
    test_flush();
    test_capture();
    test_req();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/em_pipe_reg.md
# em_pipe_reg

Pipeline register between the Execute and Memory stages of the P8 pipelined MIPS core. It captures the Execute-stage instruction bundle, including the merged exception code and the branch-delay flag, and presents it to the Memory stage and CP0. It also handles three special loads:

- bubble insertion on an Execute-stage flush;
- a full flush on an exception or interrupt request;
- squashing of architectural side effects for instructions that already carry an exception.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value of M_PC after reset
- HANDLER_PC, 32'h0000_4180, value of M_PC loaded on Req

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Req  in  1  CP0 exception/interrupt request; flushes this register
- en  in  1  load enable; 0 = hold
- flush  in  1  insert bubble (Execute stalled, e.g. MDU busy)
- E_PC  in  32  Execute-stage PC
- E_Instr  in  32  Execute-stage instruction word
- E_ExcCode  in  5  merged Execute exception code, 0 = none
- E_BD  in  1  instruction sits in a branch delay slot
- E_ALUOut  in  32  ALU result / memory address
- E_RtData  in  32  forwarded rt value (store data)
- E_RegAddr  in  5  destination GPR, 0 = no write
- E_MemWrEn  in  1  store request
- E_Tnew  in  2  cycles until result ready, as seen in Execute
- M_PC, M_Instr, M_ExcCode, M_BD, M_ALUOut, M_RtData, M_RegAddr, M_MemWrEn  out  widths as above  registered copies
- M_Tnew  out  2  Tnew as seen in Memory
- M_Valid  out  1  1 = real instruction, 0 = bubble

## Operation
Priority per rising edge, highest first: reset, Req, flush, en, hold.

- **reset (async):**
  - M_PC = RESET_PC.
  - All other outputs = 0, including M_Valid = 0.
- **Req = 1:**
  - M_PC = HANDLER_PC.
  - M_BD = 0, M_Valid = 0.
  - All other outputs = 0.
  - Overrides flush and en.
- **flush = 1 (Req = 0):**
  - Bubble with M_PC = E_PC and M_BD = E_BD, so CP0 still sees the correct macroscopic PC/BD for EPC.
  - M_Valid = 0.
  - M_Instr, M_ExcCode, M_ALUOut, M_RtData, M_RegAddr, M_MemWrEn and M_Tnew = 0.
  - Takes effect regardless of en.
- **en = 1 (Req = 0, flush = 0):**
  - Capture all E_* inputs; M_Valid = 1.
  - M_Tnew = (E_Tnew == 0) ? 0 : E_Tnew − 1. Saturating; 2-bit, never wraps to 3.
  - Exception squash: if E_ExcCode != 0, then M_RegAddr = 0 and M_MemWrEn = 0. M_ExcCode, M_PC, M_BD and M_ALUOut are still captured so CP0 records BadVAddr/EPC.
- **en = 0, no Req/flush:** all outputs hold.
- No combinational paths from inputs to outputs; every output is a flop.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Req sampled at edge N: handler bubble visible after edge N. The upstream instruction at that edge is discarded.
- Simultaneous Req, flush and en: Req wins.
- Simultaneous flush and en: flush wins.
- Reset asserted mid-operation: outputs go to reset values immediately, with no clock needed. The first capture happens on the first edge after reset deasserts, provided en = 1.

## Configuration
- EM_BD_TRACK_EN
  - Defined: M_BD is registered as described above.
  - Undefined: M_BD is tied to 0, E_BD is ignored, and no BD flop is instantiated. Used for builds without delay-slot exception support.

## Test plan
- Reset then release, no en:
  - M_PC = 32'h0000_3000, M_Valid = 0, all other outputs 0.
  - Outputs hold across 3 edges.
- en = 1 with E_PC = 32'h0000_3010, E_RegAddr = 8, E_Tnew = 2, E_ExcCode = 0:
  - Next cycle M_PC = 32'h0000_3010, M_RegAddr = 8, M_Tnew = 1, M_Valid = 1.
  - Repeat with E_Tnew = 0 → M_Tnew = 0.
- en = 1 with E_ExcCode = 5'd4, E_RegAddr = 9, E_MemWrEn = 1, E_ALUOut = 32'h0000_0001:
  - M_ExcCode = 4, M_ALUOut = 32'h0000_0001.
  - M_RegAddr = 0, M_MemWrEn = 0.
- flush = 1 and en = 1 with E_PC = 32'h0000_3020, E_BD = 1:
  - M_PC = 32'h0000_3020, M_BD = 1 (0 when EM_BD_TRACK_EN is undefined).
  - M_Valid = 0, M_RegAddr = 0, M_Instr = 0.
- Req = 1 together with flush = 1, en = 1 and a valid E bundle:
  - M_PC = 32'h0000_4180, M_Valid = 0, M_ExcCode = 0, M_BD = 0.
- Assert reset between edges while M_Valid = 1:
  - Outputs return to reset values before the next edge.
